// File: rtl/pinky_fetch_queue.sv
// Instruction prefetch queue with CC-based squashing, SYS stop and redirect flush.
// Optional squash counter output enabled by defining PINKY_FETCH_SQUASH_CNT_EN.
module pinky_fetch_queue #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [WIDTH-1:0]           imem_data,
  input  logic                       z_flag,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_ir,
  output logic [ADDR_W-1:0]          out_pc,
  output logic                       halt,
  output logic [$clog2(DEPTH):0]     count
`ifdef PINKY_FETCH_SQUASH_CNT_EN
  ,
  output logic [15:0]                squash_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [4:0] OP_SYS = 5'b10011;
  localparam logic [WIDTH-1:0] NOP_WORD = {5'b10100, {(WIDTH-5){1'b0}}};
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {RUN, STOPPED} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [WIDTH-1:0]  ir_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];

  logic [4:0]        fetch_op;
  logic [1:0]        fetch_cc;
  logic              squash;
  logic [WIDTH-1:0]  ir_next;
  logic              enq, deq;

  assign fetch_op = imem_data[WIDTH-1:WIDTH-5];
  assign fetch_cc = imem_data[WIDTH-6:WIDTH-7];
  assign squash   = ((fetch_cc == 2'd2) && z_flag) || ((fetch_cc == 2'd3) && !z_flag);
  assign ir_next  = squash ? NOP_WORD : imem_data;

  assign enq       = (state == RUN) && (count < FULL_CNT) && !redirect;
  assign out_valid = (count != '0) && !redirect;
  assign deq       = out_valid && out_ready;

  assign imem_addr = pc;
  assign out_ir    = ir_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Only an unsquashed SYS stops fetch; a redirect always restarts it.
  always_comb begin
    state_next = state;
    if (redirect)
      state_next = RUN;
    else if (enq && !squash && (fetch_op == OP_SYS))
      state_next = STOPPED;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= '0;
    else if (redirect) pc <= redirect_pc;
    else if (enq)      pc <= pc + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ir_mem[wr_ptr] <= ir_next;
      pc_mem[wr_ptr] <= pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (!enq && deq) count <= count - CNT_W'(1);
    end
  end

  // Halt is sticky: once a SYS leaves the queue only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      halt <= 1'b0;
    else if (deq && (out_ir[WIDTH-1:WIDTH-5] == OP_SYS))
      halt <= 1'b1;
  end

`ifdef PINKY_FETCH_SQUASH_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      squash_cnt <= '0;
    else if (enq && squash && (squash_cnt != 16'hFFFF))
      squash_cnt <= squash_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pinky_fetch_queue.sv
// Self-checking bench for pinky_fetch_queue: directed scenarios plus random traffic
// against a queue-based reference model. Honours PINKY_FETCH_SQUASH_CNT_EN.
module tb_pinky_fetch_queue;

  localparam logic [4:0] OP_SYS = 5'b10011;
  localparam logic [15:0] ADD_WORD = 16'h0123;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        z_flag;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ir;
  logic [15:0] out_pc;
  logic        halt;
  logic [2:0]  count;
`ifdef PINKY_FETCH_SQUASH_CNT_EN
  logic [15:0] squash_cnt;
`endif

  logic [15:0] rom [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: queue entries packed as {pc, ir}
  logic [31:0] m_q[$];
  logic [15:0] m_pc;
  logic        m_stop;
  logic        m_halt;
  logic [15:0] m_sc;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr[7:0]];

  pinky_fetch_queue #(.WIDTH(16), .ADDR_W(16), .DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .z_flag(z_flag),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ir(out_ir),
    .out_pc(out_pc),
    .halt(halt),
    .count(count)
`ifdef PINKY_FETCH_SQUASH_CNT_EN
    ,
    .squash_cnt(squash_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_pc   = 16'h0000;
    m_stop = 1'b0;
    m_halt = 1'b0;
    m_sc   = 16'h0000;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model
  task automatic applyStimulus(input logic rdr, input logic [15:0] rpc,
                               input logic rdy, input logic z);
    logic [15:0] word;
    logic [15:0] irp;
    logic [31:0] head;
    logic        sq;
    logic        can_enq;
    redirect    = rdr;
    redirect_pc = rpc;
    out_ready   = rdy;
    z_flag      = z;
    @(negedge clk);
    #1;
    checkOutput("imem_addr", {16'h0, imem_addr}, {16'h0, m_pc});
    checkOutput("count", {29'h0, count}, m_q.size());
    checkOutput("out_valid", {31'h0, out_valid}, {31'h0, (m_q.size() != 0) && !rdr});
    if ((m_q.size() != 0) && !rdr) begin
      checkOutput("out_pc", {16'h0, out_pc}, {16'h0, m_q[0][31:16]});
      checkOutput("out_ir", {16'h0, out_ir}, {16'h0, m_q[0][15:0]});
    end
    checkOutput("halt", {31'h0, halt}, {31'h0, m_halt});
`ifdef PINKY_FETCH_SQUASH_CNT_EN
    checkOutput("squash_cnt", {16'h0, squash_cnt}, {16'h0, m_sc});
`endif
    word = rom[m_pc[7:0]];
    sq   = ((word[10:9] == 2'd2) && z) || ((word[10:9] == 2'd3) && !z);
    irp  = sq ? 16'hA000 : word;
    if (rdr) begin
      m_q.delete();
      m_pc   = rpc;
      m_stop = 1'b0;
    end else begin
      can_enq = !m_stop && (m_q.size() < 4);
      if ((m_q.size() != 0) && rdy) begin
        head = m_q.pop_front();
        if (head[15:11] == OP_SYS) m_halt = 1'b1;
      end
      if (can_enq) begin
        m_q.push_back({m_pc, irp});
        m_pc = m_pc + 16'd1;
        if (!sq && (word[15:11] == OP_SYS)) m_stop = 1'b1;
        if (sq && (m_sc != 16'hFFFF)) m_sc = m_sc + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = ADD_WORD;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0; out_ready = 1'b0; z_flag = 1'b0;
    modelReset();
    #3;
    checkOutput("rst_count", {29'h0, count}, 32'd0);
    checkOutput("rst_addr", {16'h0, imem_addr}, 32'd0);
    checkOutput("rst_halt", {31'h0, halt}, 32'd0);
    checkOutput("rst_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill with decode stalled
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("fill_count", {29'h0, count}, 32'd4);
    checkOutput("fill_addr", {16'h0, imem_addr}, 32'd4);
    checkOutput("fill_pc", {16'h0, out_pc}, 32'd0);
    checkOutput("fill_valid", {31'h0, out_valid}, 32'd1);

    // Streaming: full queue first drains by one, then stays steady
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      checkOutput("stream_pc", {16'h0, out_pc}, i + 1);
      checkOutput("stream_count", {29'h0, count}, 32'd3);
    end

    // Squash of CC=3 word with Z clear
    rom[2] = 16'h0600;
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("squash_pc", {16'h0, out_pc}, 32'd2);
    checkOutput("squash_ir", {16'h0, out_ir}, 32'hA000);
`ifdef PINKY_FETCH_SQUASH_CNT_EN
    checkOutput("squash_cnt1", {16'h0, squash_cnt}, 32'd1);
`endif
    rom[2] = ADD_WORD;

    // SYS at address 3 stops fetch and raises halt after its dequeue
    rom[3] = 16'h9800;
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("sys_addr", {16'h0, imem_addr}, 32'd4);
    checkOutput("sys_halt_pre", {31'h0, halt}, 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("sys_halt", {31'h0, halt}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("sys_addr_hold", {16'h0, imem_addr}, 32'd4);

    // Redirect while full
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0);
    checkOutput("redir_count", {29'h0, count}, 32'd0);
    checkOutput("redir_addr", {16'h0, imem_addr}, 32'h40);
    checkOutput("redir_halt", {31'h0, halt}, 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("redir_pc", {16'h0, out_pc}, 32'h40);

    // PC wrap-around
    applyStimulus(1'b1, 16'hFFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("wrap_count", {29'h0, count}, 32'd2);
    checkOutput("wrap_addr", {16'h0, imem_addr}, 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("wrap_pc", {16'h0, out_pc}, 32'd0);

    // Asynchronous reset with three entries queued
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("pre_rst_count", {29'h0, count}, 32'd3);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_count", {29'h0, count}, 32'd0);
    checkOutput("async_halt", {31'h0, halt}, 32'd0);
    checkOutput("async_addr", {16'h0, imem_addr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();

    // Random traffic
    for (int i = 0; i < 256; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 15) == 0) ? OP_SYS : 5'($urandom);
      rom[i] = {op, 2'($urandom), 9'($urandom)};
    end
    for (int i = 0; i < 500; i++) begin
      logic        rdr;
      logic [15:0] rpc;
      rdr = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      applyStimulus(rdr, rpc, ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pinky_fetch_queue.md
PINKY_FETCH_QUEUE -- requirements
Module: pinky_fetch_queue

Interface
REQ-001 Parameter WIDTH, default 16: instruction word width in bits; opcode is bits [WIDTH-1:WIDTH-5] and CC is bits [WIDTH-6:WIDTH-7].
REQ-002 Parameter ADDR_W, default 16: PC and instruction address width in bits.
REQ-003 Parameter DEPTH, default 4: prefetch queue entries; SHALL be a power of two and >= 2.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 imem_addr  output  ADDR_W  fetch address; equals the current PC.
REQ-007 imem_data  input  WIDTH  instruction at imem_addr, valid combinationally in the same cycle.
REQ-008 z_flag  input  1  current Z flag, used for the CC squash decision.
REQ-009 redirect  input  1  PC-write / branch request; flushes the queue.
REQ-010 redirect_pc  input  ADDR_W  new PC value when redirect=1.
REQ-011 out_valid  output  1  queue head is presented to decode.
REQ-012 out_ready  input  1  decode accepts the head this cycle.
REQ-013 out_ir  output  WIDTH  head instruction word.
REQ-014 out_pc  output  ADDR_W  PC of the head instruction.
REQ-015 halt  output  1  registered; SYS instruction has retired from the queue.
REQ-016 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-017 States: RUN and STOPPED; fetch occurs only in RUN.
REQ-018 Enqueue condition: RUN, count<DEPTH and redirect=0; the queue writes {PC, ir'} and PC<=PC+1 modulo 2^ADDR_W.
REQ-019 Squash: ir' = {5'b10100, zeros} (NOP) when (CC==2 and z_flag==1) or (CC==3 and z_flag==0); otherwise ir' = imem_data.
REQ-020 When the enqueued unsquashed opcode is SYS (5'b10011), the queue writes it and the state moves RUN->STOPPED; a squashed SYS does not stop fetch.
REQ-021 out_valid = (count!=0) and not redirect; out_ir/out_pc reflect the head entry; a dequeue occurs when out_valid and out_ready.
REQ-022 Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
REQ-023 Full (count==DEPTH): no enqueue, even with a same-cycle dequeue.
REQ-024 Empty: out_valid=0; out_ir and out_pc hold their last value and have no meaning.
REQ-025 Pointers wrap modulo DEPTH.
REQ-026 Redirect has priority over everything: count, rd_ptr and wr_ptr <= 0, PC <= redirect_pc, state <= RUN, no enqueue or dequeue that cycle, halt unchanged.
REQ-027 halt <= 1 on the cycle after a SYS entry is dequeued; halt stays 1 until reset.
REQ-028 imem_addr = PC at all times, including in STOPPED.

Reset
REQ-029 While reset=1, immediately and regardless of clk: PC=0, count=0, both pointers 0, state RUN, halt=0, and squash_cnt=0 when present.
REQ-030 Reset asserted mid-operation discards all queued entries; fetch resumes from address 0 on the first rising clk edge after reset deasserts.

Configuration
REQ-031 Macro PINKY_FETCH_SQUASH_CNT_EN: when defined, an extra output squash_cnt (output, 16 bits) is present; it increments by 1 on every enqueue of a squashed instruction, saturates at 16'hFFFF, and is unaffected by redirect.
REQ-032 Without PINKY_FETCH_SQUASH_CNT_EN: no squash_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-033 Reset, imem holds ADD words, out_ready=0 for 6 cycles -> count=4, imem_addr=4, out_pc=0, out_valid=1.
REQ-034 out_ready=1 continuously, streaming -> out_pc sequence 0,1,2,3,... one per cycle after the first fill; count steady.
REQ-035 Word at address 2 with CC=3 and z_flag=0 -> entry pc=2 carries out_ir=16'hA000; squash_cnt=1 when the macro is defined.
REQ-036 SYS at address 3, out_ready=1 -> fetch stops with imem_addr=4; halt=1 the cycle after the pc=3 dequeue.
REQ-037 Queue full plus redirect=1 with redirect_pc=16'h0040 -> next cycle count=0 and imem_addr=16'h0040; next entry dequeued has out_pc=16'h0040.
REQ-038 PC=16'hFFFF with ADDR_W=16 -> next enqueued entry has pc=0; reset asserted with count=3 -> count=0 and halt=0 without a clock edge.
